hw2_op_issue: RTL and testbench

- Upstream operand-issue stage for the clock-gated (a±b)*c datapath (hw2_cg).
- Accepts operand tuples {a, b, c, s} over a valid/ready handshake and buffers them in a small FIFO.
- Presents one tuple per cycle to the datapath, together with a gating enable.
- Produces a result-valid strobe aligned with the datapath output d, so downstream logic captures only meaningful results.

---
 rtl/hw2_pkg.sv | 16 +
 rtl/hw2_sync_fifo.sv | 60 ++++++
 rtl/hw2_op_issue.sv | 97 +++++++++
 tb/tb_hw2_op_issue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hw2_pkg.sv
// Shared constants and operand tuple type for the hw2 operand-issue slice.
// Defaults feed the parameters of hw2_op_issue and hw2_sync_fifo.
package hw2_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int LAT_DEF   = 2;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [WIDTH_DEF-1:0] c;
        logic                 s;
    } op_t;

endpackage

// File: rtl/hw2_sync_fifo.sv
// Parameterised synchronous FIFO with level, full and empty.
// Pointers carry one extra wrap bit to tell full from empty.
module hw2_sync_fifo
    import hw2_pkg::*;
#(
    parameter int DW    = 3 * WIDTH_DEF + 1,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hw2_op_issue.sv
// Operand-issue stage for the clock-gated (a+-b)*c datapath: buffers tuples,
// issues one per cycle with a gate enable, and flags when d is valid.
module hw2_op_issue
    import hw2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH-1:0]       in_c,
    input  logic                   in_s,
    input  logic                   hold,
    output logic [WIDTH-1:0]       a,
    output logic [WIDTH-1:0]       b,
    output logic [WIDTH-1:0]       c,
    output logic                   s,
    output logic                   en,
    output logic                   res_valid,
    output logic [15:0]            issue_cnt,
    output logic [$clog2(DEPTH):0] level
);

    localparam int DW = 3 * WIDTH + 1;

    logic [DW-1:0]  head;
    logic           full;
    logic           empty;
    logic           do_push;
    logic           do_pop;

    logic [DW-1:0]  op_q, op_d;
    logic           en_q, en_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [LAT-1:0] sr_q, sr_d;
    logic [LAT:0]   sr_ext;

    assign in_ready = !full;
    assign do_push  = in_valid && in_ready;
    assign do_pop   = !empty && !hold;

    hw2_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .wdata ({in_a, in_b, in_c, in_s}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Operands only change on an issue, so gated logic sees no toggling.
    always_comb begin
        op_d   = op_q;
        en_d   = do_pop;
        cnt_d  = cnt_q;
        if (do_pop) begin
            op_d  = head;
            cnt_d = cnt_q + 16'd1;
        end
        sr_ext = {sr_q, en_q};
        sr_d   = sr_ext[LAT-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            en_q  <= 1'b0;
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            op_q  <= op_d;
            en_q  <= en_d;
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign a         = op_q[DW-1 -: WIDTH];
    assign b         = op_q[DW-1-WIDTH -: WIDTH];
    assign c         = op_q[WIDTH:1];
    assign s         = op_q[0];
    assign en        = en_q;
    assign res_valid = sr_q[LAT-1];
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_hw2_op_issue.sv
// Self-checking bench for hw2_op_issue against a queue-based reference model.
module tb_hw2_op_issue;
    import hw2_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int D  = DEPTH_DEF;
    localparam int L  = LAT_DEF;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b, in_c;
    logic          in_s;
    logic          hold;
    logic [W-1:0]  a, b, c;
    logic          s;
    logic          en;
    logic          res_valid;
    logic [15:0]   issue_cnt;
    logic [LW-1:0] level;

    hw2_op_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_s      (in_s),
        .hold      (hold),
        .a         (a),
        .b         (b),
        .c         (c),
        .s         (s),
        .en        (en),
        .res_valid (res_valid),
        .issue_cnt (issue_cnt),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue plus a delay line of enables.
    op_t         mq[$];
    bit          hist[$];
    op_t         m_op;
    bit          m_en;
    bit          m_rv;
    int unsigned m_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int rv_seen = 0;
    int a5_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        hist.delete();
        repeat (L) hist.push_back(1'b0);
        m_op  = '0;
        m_en  = 1'b0;
        m_rv  = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit   acc;
        op_t  t;
        acc = in_valid && (mq.size() < D);
        t   = '{a: in_a, b: in_b, c: in_c, s: in_s};
        if (mq.size() > 0 && !hold) begin
            m_op  = mq.pop_front();
            m_en  = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
        end else begin
            m_en = 1'b0;
        end
        if (acc) mq.push_back(t);
        hist.push_back(m_en);
        m_rv = hist.pop_front();
    endtask

    task automatic check_all();
        chk("en", 32'(en), 32'(m_en));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("level", 32'(level), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < D));
        chk("issue_cnt", 32'(issue_cnt), m_cnt);
        chk("ops", 32'({a, b, c, s}), 32'(m_op));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (res_valid) rv_seen++;
        if (en && a == W'(5) && a5_seen >= 0) a5_seen++;
    endtask

    task automatic drive(input bit v, input bit h);
        in_valid = v;
        hold     = h;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_c     = W'($urandom);
        in_s     = 1'($urandom);
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0);
        model_reset();
        #2;
        check_all();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #10 rst = 1'b0;

        // Single tuple {3,5,7,1}
        in_valid = 1'b1; hold = 1'b0;
        in_a = 3; in_b = 5; in_c = 7; in_s = 1'b1;
        step();
        chk("single_en_early", 32'(en), 32'd0);
        drive(1'b0, 1'b0);
        step();
        chk("single_en", 32'(en), 32'd1);
        chk("single_ops", 32'({a, b, c, s}), 32'({8'd3, 8'd5, 8'd7, 1'b1}));
        chk("single_cnt", 32'(issue_cnt), 32'd1);
        step();
        chk("single_rv_early", 32'(res_valid), 32'd0);
        step();
        chk("single_rv", 32'(res_valid), 32'd1);
        step();

        // Fill under hold; fifth push must be dropped
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1);
            in_a = W'(i);
            step();
        end
        chk("fill_level", 32'(level), 32'(D));
        chk("fill_ready", 32'(in_ready), 32'd0);
        a5_seen = 0;
        drive(1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_a", 32'(a), 32'(i));
        end
        repeat (4) step();
        chk("a5_dropped", 32'(a5_seen), 32'd0);

        // Streaming 100 tuples
        do_reset();
        rv_seen = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0);
            step();
            if (i > 0) chk("stream_level", 32'(level), 32'd1);
        end
        drive(1'b0, 1'b0);
        step();
        chk("stream_cnt", 32'(issue_cnt), 32'd100);

        // Idle stability with empty FIFO
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'($urandom));
            step();
        end
        chk("stream_rv", 32'(rv_seen), 32'd100);
        chk("idle_rv", 32'(res_valid), 32'd0);

        // Reset mid-operation: 3 buffered, 1 in flight
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1);
            step();
        end
        drive(1'b0, 1'b0);
        step();
        chk("pre_rst_en", 32'(en), 32'd1);
        chk("pre_rst_level", 32'(level), 32'd3);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_en", 32'(en), 32'd0);
        chk("mid_rst_rv", 32'(res_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_cnt", 32'(issue_cnt), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b0;
        rv_seen = 0;
        repeat (6) step();
        chk("no_stale_rv", 32'(rv_seen), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3));
            step();
        end
        drive(1'b0, 1'b0);
        repeat (8) step();

        // Counter wrap after 65536 issues
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b0);
            step();
        end
        drive(1'b0, 1'b0);
        step();
        chk("wrap_cnt", 32'(issue_cnt), 32'd0);
        chk("wrap_en", 32'(en), 32'd1);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
